// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT source-stream frame unpacker.
package fft_stream_pkg;

    localparam int unsigned EXP_W         = 6;
    localparam int unsigned DEF_FRAME_LEN = 4096;
    localparam int unsigned DEF_DATA_W    = 16;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_e;

    typedef enum logic {
        WrWaitSop,
        WrFill
    } wr_state_e;

endpackage

// File: rtl/exp_shift_sat.sv
// Registered block-exponent rescale: shift by (exp + offset), saturating on left-shift overflow.
module exp_shift_sat
    import fft_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic [EXP_W-1:0]         exp_i,
    input  logic signed [7:0]        offset_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     valid_o
);

    localparam int unsigned MaxShift = 15;
    localparam int unsigned WideW    = DATA_W + MaxShift;

    logic signed [7:0]       shift_amt;
    logic signed [7:0]       neg_amt;
    logic [3:0]              sh;
    logic [WideW-1:0]        wide;
    logic [MaxShift:0]       upper;
    logic [DATA_W-1:0]       result;
    logic [DATA_W-1:0]       data_d, data_q;
    logic                    valid_q;

    always_comb begin
        shift_amt = $signed({{(8 - EXP_W){exp_i[EXP_W-1]}}, exp_i}) + offset_i;
        neg_amt   = -shift_amt;
        sh        = 4'd0;
        wide      = {{MaxShift{sample_i[DATA_W-1]}}, sample_i};
        upper     = '0;
        result    = '0;
        if (!shift_amt[7]) begin
            sh    = (shift_amt > 8'sd15) ? 4'd15 : shift_amt[3:0];
            wide  = wide << sh;
            upper = wide[WideW-1:DATA_W-1];
            // Result fits only if every bit above the new sign bit matches it.
            if ((&upper) || (~|upper)) begin
                result = wide[DATA_W-1:0];
            end else if (wide[WideW-1]) begin
                result = {1'b1, {(DATA_W - 1){1'b0}}};
            end else begin
                result = {1'b0, {(DATA_W - 1){1'b1}}};
            end
        end else begin
            sh     = (neg_amt > 8'sd15) ? 4'd15 : neg_amt[3:0];
            result = sample_i >>> sh;
        end
        data_d = valid_i ? result : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_i;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fft_frame_unpacker.sv
// Receives FFT source frames into a ping-pong buffer and replays them, exponent-scaled, on request.
module fft_frame_unpacker
    import fft_stream_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int          EXP_OFFSET = 12
) (
    input  logic              fft_clk,
    input  logic              reset_n,
    input  logic              src_valid,
    input  logic              src_sop,
    input  logic              src_eop,
    input  logic [DATA_W-1:0] src_real,
    input  logic [EXP_W-1:0]  src_exp,
    output logic              src_ready,
    input  logic              smp_req,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    output logic              underrun,
    output logic              frame_err
);

    localparam int unsigned       AW      = $clog2(FRAME_LEN);
    localparam logic [AW-1:0]     LastIdx = AW'(FRAME_LEN - 1);
    localparam logic signed [7:0] ExpOffs = 8'(EXP_OFFSET);

    wr_state_e         wr_state_q, wr_state_d;
    bank_state_e       bank_st_q [2];
    bank_state_e       bank_st_d [2];
    logic [EXP_W-1:0]  bank_exp_q [2];
    logic [EXP_W-1:0]  bank_exp_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AW-1:0]     wr_idx_q, wr_idx_d;
    logic [AW-1:0]     rd_idx_q, rd_idx_d;
    logic              frame_err_q, frame_err_d;

    logic              accept, readable, rd_fire, at_last, mem_we;
    logic [AW:0]       wr_addr, rd_addr;

    logic [DATA_W-1:0] mem [2*FRAME_LEN];
    logic [DATA_W-1:0] mem_rd_q;
    logic              s1_valid_q, s1_und_q, underrun_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [DATA_W-1:0] s1_sample;

    // Only registered bank state feeds ready, so there is no path from src_valid.
    assign src_ready = (bank_st_q[wr_bank_q] == BankEmpty) ||
                       (bank_st_q[wr_bank_q] == BankFilling);
    assign accept    = src_valid && src_ready;
    assign readable  = (bank_st_q[rd_bank_q] == BankFull) ||
                       (bank_st_q[rd_bank_q] == BankDraining);
    assign rd_fire   = smp_req && readable;
    assign at_last   = (wr_idx_q == LastIdx);
    assign wr_addr   = {wr_bank_q, (src_sop ? {AW{1'b0}} : wr_idx_q)};
    assign rd_addr   = {rd_bank_q, rd_idx_q};

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        bank_st_d   = bank_st_q;
        bank_exp_d  = bank_exp_q;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;

        if (accept) begin
            unique case (wr_state_q)
                WrWaitSop: begin
                    if (src_sop && !src_eop) begin
                        mem_we                = 1'b1;
                        bank_exp_d[wr_bank_q] = src_exp;
                        bank_st_d[wr_bank_q]  = BankFilling;
                        wr_idx_d              = AW'(1);
                        wr_state_d            = WrFill;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                WrFill: begin
                    if (src_sop && !src_eop) begin
                        // Restart the frame in place; the partial data is simply overwritten.
                        mem_we                = 1'b1;
                        frame_err_d           = 1'b1;
                        bank_exp_d[wr_bank_q] = src_exp;
                        wr_idx_d              = AW'(1);
                    end else if (src_sop || (src_eop != at_last)) begin
                        frame_err_d          = 1'b1;
                        bank_st_d[wr_bank_q] = BankEmpty;
                        wr_state_d           = WrWaitSop;
                        wr_idx_d             = '0;
                    end else if (at_last) begin
                        mem_we               = 1'b1;
                        bank_st_d[wr_bank_q] = BankFull;
                        wr_bank_d            = ~wr_bank_q;
                        wr_state_d           = WrWaitSop;
                        wr_idx_d             = '0;
                    end else begin
                        mem_we   = 1'b1;
                        wr_idx_d = wr_idx_q + AW'(1);
                    end
                end
                default: ;
            endcase
        end

        // The read bank is never EMPTY/FILLING, so it never collides with the write update.
        if (rd_fire) begin
            bank_st_d[rd_bank_q] = BankDraining;
            if (rd_idx_q == LastIdx) begin
                bank_st_d[rd_bank_q] = BankEmpty;
                rd_bank_d            = ~rd_bank_q;
                rd_idx_d             = '0;
            end else begin
                rd_idx_d = rd_idx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge fft_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q    <= WrWaitSop;
            bank_st_q[0]  <= BankEmpty;
            bank_st_q[1]  <= BankEmpty;
            bank_exp_q[0] <= '0;
            bank_exp_q[1] <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            frame_err_q   <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_und_q      <= 1'b0;
            s1_exp_q      <= '0;
            underrun_q    <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            bank_st_q     <= bank_st_d;
            bank_exp_q    <= bank_exp_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            frame_err_q   <= frame_err_d;
            s1_valid_q    <= smp_req;
            s1_und_q      <= smp_req && !readable;
            s1_exp_q      <= rd_fire ? bank_exp_q[rd_bank_q] : s1_exp_q;
            underrun_q    <= s1_und_q;
        end
    end

    always_ff @(posedge fft_clk) begin
        if (mem_we) begin
            mem[wr_addr] <= src_real;
        end
        if (rd_fire) begin
            mem_rd_q <= mem[rd_addr];
        end
    end

    assign s1_sample = s1_und_q ? '0 : mem_rd_q;

    exp_shift_sat #(
        .DATA_W (DATA_W)
    ) u_scale (
        .clk_i    (fft_clk),
        .rst_ni   (reset_n),
        .valid_i  (s1_valid_q),
        .sample_i (s1_sample),
        .exp_i    (s1_exp_q),
        .offset_i (ExpOffs),
        .data_o   (smp_data),
        .valid_o  (smp_valid)
    );

    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule
